mean_frame_merge: RTL and testbench

Output-side companion of the streaming 7x7 mean filter. Consumes the original raster pixel stream and the filter's centre-tagged mean stream, and re-emits one complete raster-order frame. Border pixels (no full 7x7 window) carry the original value; interior pixels carry the filter mean. Sits between the filter and frame-level sinks (writers, display), replacing bench-side pixel collection.

---
 rtl/mean_frame_merge.sv | 295 +++++++++++++++++++++++++++++
 tb/tb_mean_frame_merge.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mean_frame_merge.sv
// Re-assembles a raster frame from the original pixel stream and the 7x7 mean stream:
// border pixels replay the buffered original, interior pixels take the centre-tagged mean.
module mean_frame_merge #(
    parameter int IMAGE_WIDTH  = 320,
    parameter int IMAGE_HEIGHT = 240,
    parameter int BORDER       = 3,
    parameter int BUF_LINES    = 8,
    parameter int MFIFO_DEPTH  = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        gray_valid,
    input  logic [7:0]  gray,
    input  logic        mean_valid,
    input  logic [7:0]  mean_out,
    input  logic [15:0] center_row,
    input  logic [15:0] center_col,
    output logic        pix_valid,
    output logic [7:0]  pix_out,
    output logic [15:0] pix_row,
    output logic [15:0] pix_col,
    output logic        frame_done,
    output logic        overflow,
    output logic        sync_err
);

    localparam int FRAME_PIX = IMAGE_WIDTH * IMAGE_HEIGHT;
    localparam int BUF_DEPTH = BUF_LINES * IMAGE_WIDTH;
    localparam int CNT_MAX   = (FRAME_PIX > BUF_DEPTH) ? FRAME_PIX : BUF_DEPTH;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);
    localparam int ADDR_W    = $clog2(BUF_DEPTH);
    localparam int LINE_W    = $clog2(BUF_LINES);
    localparam int MF_AW     = $clog2(MFIFO_DEPTH);
    localparam int PTR_W     = MF_AW + 1;

    localparam logic [CNT_W-1:0]  FRAME_PIX_C = CNT_W'(FRAME_PIX);
    localparam logic [CNT_W-1:0]  BUF_DEPTH_C = CNT_W'(BUF_DEPTH);
    localparam logic [ADDR_W-1:0] WIDTH_A     = ADDR_W'(IMAGE_WIDTH);
    localparam logic [15:0]       ROW_LAST    = 16'(IMAGE_HEIGHT - 1);
    localparam logic [15:0]       COL_LAST    = 16'(IMAGE_WIDTH - 1);
    localparam logic [15:0]       EDGE_LO     = 16'(BORDER);
    localparam logic [15:0]       ROW_HI      = 16'(IMAGE_HEIGHT - BORDER);
    localparam logic [15:0]       COL_HI      = 16'(IMAGE_WIDTH - BORDER);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    state_e state_q, state_d;

    logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
    logic [15:0]      wr_row_q, wr_row_d;
    logic [15:0]      wr_col_q, wr_col_d;
    logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
    logic [15:0]      rd_row_q, rd_row_d;
    logic [15:0]      rd_col_q, rd_col_d;

    logic [7:0]       buf_mem [0:BUF_DEPTH-1];
    logic [7:0]       rd_data_q;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;

    logic [39:0]      fifo_mem [0:MFIFO_DEPTH-1];
    logic [PTR_W-1:0] fifo_wp_q, fifo_wp_d;
    logic [PTR_W-1:0] fifo_rp_q, fifo_rp_d;
    logic             fifo_empty;
    logic             fifo_full;
    logic [39:0]      fifo_head;

    logic             s1_valid_q;
    logic             s1_use_mean_q;
    logic [7:0]       s1_mean_q;
    logic [15:0]      s1_row_q;
    logic [15:0]      s1_col_q;
    logic             s1_last_q;

    logic             pix_valid_q;
    logic [7:0]       pix_out_q;
    logic [15:0]      pix_row_q;
    logic [15:0]      pix_col_q;
    logic             frame_done_q;
    logic             overflow_q;
    logic             sync_err_q;

    logic             wr_drop;
    logic             wr_accept;
    logic             mean_push;
    logic             rd_border;
    logic             rd_last;
    logic             issue;
    logic             issue_mean;
    logic             pop;
    logic             sync_hit;
    logic             cnt_clr;

    // Writes are refused until frame_done has gone out, and whenever the line buffer is full.
    assign wr_drop   = (wr_cnt_q == FRAME_PIX_C) || frame_done_q ||
                       ((wr_cnt_q - rd_cnt_q) == BUF_DEPTH_C);
    assign wr_accept = gray_valid && !wr_drop;
    assign mean_push = mean_valid && !fifo_full;

    assign fifo_empty = (fifo_wp_q == fifo_rp_q);
    assign fifo_full  = (fifo_wp_q[MF_AW] != fifo_rp_q[MF_AW]) &&
                        (fifo_wp_q[MF_AW-1:0] == fifo_rp_q[MF_AW-1:0]);
    assign fifo_head  = fifo_mem[fifo_rp_q[MF_AW-1:0]];

    assign rd_border = (rd_row_q < EDGE_LO) || (rd_row_q >= ROW_HI) ||
                       (rd_col_q < EDGE_LO) || (rd_col_q >= COL_HI);
    assign rd_last   = (rd_row_q == ROW_LAST) && (rd_col_q == COL_LAST);

    assign wr_addr = ADDR_W'(wr_row_q[LINE_W-1:0]) * WIDTH_A + ADDR_W'(wr_col_q);
    assign rd_addr = ADDR_W'(rd_row_q[LINE_W-1:0]) * WIDTH_A + ADDR_W'(rd_col_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // One read candidate per cycle; a mismatching mean head is discarded without advancing.
    always_comb begin
        state_d    = state_q;
        issue      = 1'b0;
        issue_mean = 1'b0;
        pop        = 1'b0;
        sync_hit   = 1'b0;
        cnt_clr    = 1'b0;
        case (state_q)
            IDLE: begin
                if (wr_accept) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (rd_border) begin
                    issue = (wr_cnt_q > rd_cnt_q);
                end else if (!fifo_empty) begin
                    pop = 1'b1;
                    if (fifo_head[31:16] == rd_row_q && fifo_head[15:0] == rd_col_q) begin
                        issue      = 1'b1;
                        issue_mean = 1'b1;
                    end else begin
                        sync_hit = 1'b1;
                    end
                end
                if (issue && rd_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                cnt_clr = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        wr_cnt_d = wr_cnt_q;
        wr_row_d = wr_row_q;
        wr_col_d = wr_col_q;
        if (cnt_clr) begin
            wr_cnt_d = '0;
            wr_row_d = '0;
            wr_col_d = '0;
        end else if (wr_accept) begin
            wr_cnt_d = wr_cnt_q + CNT_W'(1);
            if (wr_col_q == COL_LAST) begin
                wr_col_d = '0;
                wr_row_d = wr_row_q + 16'd1;
            end else begin
                wr_col_d = wr_col_q + 16'd1;
            end
        end
    end

    always_comb begin
        rd_cnt_d = rd_cnt_q;
        rd_row_d = rd_row_q;
        rd_col_d = rd_col_q;
        if (cnt_clr) begin
            rd_cnt_d = '0;
            rd_row_d = '0;
            rd_col_d = '0;
        end else if (issue) begin
            rd_cnt_d = rd_cnt_q + CNT_W'(1);
            if (rd_col_q == COL_LAST) begin
                rd_col_d = '0;
                rd_row_d = rd_row_q + 16'd1;
            end else begin
                rd_col_d = rd_col_q + 16'd1;
            end
        end
    end

    always_comb begin
        fifo_wp_d = fifo_wp_q;
        fifo_rp_d = fifo_rp_q;
        if (cnt_clr) begin
            fifo_wp_d = '0;
            fifo_rp_d = '0;
        end else begin
            if (mean_push) begin
                fifo_wp_d = fifo_wp_q + PTR_W'(1);
            end
            if (pop) begin
                fifo_rp_d = fifo_rp_q + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt_q  <= '0;
            wr_row_q  <= '0;
            wr_col_q  <= '0;
            rd_cnt_q  <= '0;
            rd_row_q  <= '0;
            rd_col_q  <= '0;
            fifo_wp_q <= '0;
            fifo_rp_q <= '0;
        end else begin
            wr_cnt_q  <= wr_cnt_d;
            wr_row_q  <= wr_row_d;
            wr_col_q  <= wr_col_d;
            rd_cnt_q  <= rd_cnt_d;
            rd_row_q  <= rd_row_d;
            rd_col_q  <= rd_col_d;
            fifo_wp_q <= fifo_wp_d;
            fifo_rp_q <= fifo_rp_d;
        end
    end

    // Storage arrays carry no reset; pointers and counters define what is valid.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            buf_mem[wr_addr] <= gray;
        end
        rd_data_q <= buf_mem[rd_addr];
    end

    always_ff @(posedge clk) begin
        if (mean_push) begin
            fifo_mem[fifo_wp_q[MF_AW-1:0]] <= {mean_out, center_row, center_col};
        end
    end

    // Stage 1 holds the issue decision while the buffer read completes; stage 2 drives the ports.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q    <= 1'b0;
            s1_use_mean_q <= 1'b0;
            s1_mean_q     <= '0;
            s1_row_q      <= '0;
            s1_col_q      <= '0;
            s1_last_q     <= 1'b0;
            pix_valid_q   <= 1'b0;
            pix_out_q     <= '0;
            pix_row_q     <= '0;
            pix_col_q     <= '0;
            frame_done_q  <= 1'b0;
            overflow_q    <= 1'b0;
            sync_err_q    <= 1'b0;
        end else begin
            s1_valid_q    <= issue;
            s1_use_mean_q <= issue_mean;
            s1_mean_q     <= fifo_head[39:32];
            s1_row_q      <= rd_row_q;
            s1_col_q      <= rd_col_q;
            s1_last_q     <= issue && rd_last;
            pix_valid_q   <= s1_valid_q;
            pix_out_q     <= s1_valid_q ? (s1_use_mean_q ? s1_mean_q : rd_data_q) : 8'd0;
            pix_row_q     <= s1_valid_q ? s1_row_q : 16'd0;
            pix_col_q     <= s1_valid_q ? s1_col_q : 16'd0;
            frame_done_q  <= s1_valid_q && s1_last_q;
            overflow_q    <= overflow_q || (gray_valid && wr_drop) || (mean_valid && fifo_full);
            sync_err_q    <= sync_err_q || sync_hit;
        end
    end

    assign pix_valid  = pix_valid_q;
    assign pix_out    = pix_out_q;
    assign pix_row    = pix_row_q;
    assign pix_col    = pix_col_q;
    assign frame_done = frame_done_q;
    assign overflow   = overflow_q;
    assign sync_err   = sync_err_q;

endmodule

// File: tb/tb_mean_frame_merge.sv
// Directed bench for mean_frame_merge on an 8x8 frame with a 7x7 window;
// a second instance with a two-line buffer exercises the overflow path.
module tb_mean_frame_merge;

    localparam int W = 8;
    localparam int H = 8;
    localparam int B = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        gray_valid, mean_valid;
    logic [7:0]  gray, mean_out;
    logic [15:0] center_row, center_col;
    logic        pix_valid, frame_done, overflow, sync_err;
    logic [7:0]  pix_out;
    logic [15:0] pix_row, pix_col;

    logic        gray_valid2, mean_valid2;
    logic [7:0]  gray2, mean_out2;
    logic [15:0] center_row2, center_col2;
    logic        pix_valid2, frame_done2, overflow2, sync_err2;
    logic [7:0]  pix_out2;
    logic [15:0] pix_row2, pix_col2;

    int checkCount = 0;
    int failCount  = 0;
    int cycleCnt   = 0;
    int meanDrive33 = 0;
    int outRow[$];
    int outCol[$];
    int outPix[$];
    int outCyc[$];
    int doneIdx[$];
    int outCnt2 = 0;
    int doneCnt2 = 0;
    int lastPix2 = 0;

    always #5 clk = ~clk;

    mean_frame_merge #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .BORDER(B), .BUF_LINES(8), .MFIFO_DEPTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .gray_valid(gray_valid), .gray(gray),
        .mean_valid(mean_valid), .mean_out(mean_out), .center_row(center_row), .center_col(center_col),
        .pix_valid(pix_valid), .pix_out(pix_out), .pix_row(pix_row), .pix_col(pix_col),
        .frame_done(frame_done), .overflow(overflow), .sync_err(sync_err)
    );

    mean_frame_merge #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .BORDER(B), .BUF_LINES(2), .MFIFO_DEPTH(8)) dut2 (
        .clk(clk), .rst_n(rst_n), .gray_valid(gray_valid2), .gray(gray2),
        .mean_valid(mean_valid2), .mean_out(mean_out2), .center_row(center_row2), .center_col(center_col2),
        .pix_valid(pix_valid2), .pix_out(pix_out2), .pix_row(pix_row2), .pix_col(pix_col2),
        .frame_done(frame_done2), .overflow(overflow2), .sync_err(sync_err2)
    );

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    always @(negedge clk) begin
        if (pix_valid === 1'b1) begin
            outRow.push_back(int'(pix_row));
            outCol.push_back(int'(pix_col));
            outPix.push_back(int'(pix_out));
            outCyc.push_back(cycleCnt);
        end
        if (frame_done === 1'b1) doneIdx.push_back(outRow.size() - 1);
        if (pix_valid2 === 1'b1) begin
            outCnt2++;
            lastPix2 = int'(pix_out2);
        end
        if (frame_done2 === 1'b1) doneCnt2++;
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    function automatic int grayOf(input int r, input int c);
        return r * r * 3 + c;
    endfunction

    function automatic int meanOf(input int r, input int c);
        int sum = 0;
        for (int dr = -B; dr <= B; dr++)
            for (int dc = -B; dc <= B; dc++)
                sum += grayOf(r + dr, c + dc);
        return sum / 49;
    endfunction

    function automatic int expectedOf(input int r, input int c);
        if (r < B || r >= H - B || c < B || c >= W - B) return grayOf(r, c);
        return meanOf(r, c);
    endfunction

    task automatic setIdle();
        gray_valid = 1'b0; gray = '0; mean_valid = 1'b0; mean_out = '0;
        center_row = '0; center_col = '0;
        gray_valid2 = 1'b0; gray2 = '0; mean_valid2 = 1'b0; mean_out2 = '0;
        center_row2 = '0; center_col2 = '0;
    endtask

    task automatic clearCapture();
        outRow.delete(); outCol.delete(); outPix.delete(); outCyc.delete(); doneIdx.delete();
    endtask

    // Feeds one frame: a gray every gap+1 cycles, each mean meanDelay cycles after its window completes.
    task automatic applyStimulus(input int gap, input int meanDelay, input bit wrongFirst, input int maxCycles);
        int cr[4] = '{3, 3, 4, 4};
        int cc[4] = '{3, 4, 3, 4};
        int meanCyc[4];
        int lastCyc;
        int idx;
        for (int k = 0; k < 4; k++)
            meanCyc[k] = ((cr[k] + B) * W + cc[k] + B) * (gap + 1) + meanDelay;
        lastCyc = (63 * (gap + 1) > meanCyc[3]) ? 63 * (gap + 1) : meanCyc[3];
        for (int cyc = 0; cyc <= lastCyc && cyc < maxCycles; cyc++) begin
            gray_valid = 1'b0; mean_valid = 1'b0;
            if (cyc % (gap + 1) == 0 && cyc / (gap + 1) < W * H) begin
                idx = cyc / (gap + 1);
                gray_valid = 1'b1;
                gray = 8'(grayOf(idx / W, idx % W));
            end
            for (int k = 0; k < 4; k++) begin
                if (cyc == meanCyc[k]) begin
                    mean_valid = 1'b1;
                    mean_out = 8'(meanOf(cr[k], cc[k]));
                    center_row = 16'(cr[k]);
                    center_col = 16'(cc[k]);
                    if (k == 0) meanDrive33 = cycleCnt;
                end
            end
            if (wrongFirst && cyc == meanCyc[0] - 4) begin
                mean_valid = 1'b1;
                mean_out = 8'(meanOf(3, 4));
                center_row = 16'd3;
                center_col = 16'd4;
            end
            @(negedge clk);
        end
        setIdle();
    endtask

    task automatic waitFrameDone(input int bound);
        int n = 0;
        while (frame_done !== 1'b1 && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (frame_done !== 1'b1) checkOutput("frameDoneTimeout", 0, 1);
    endtask

    task automatic verifyFrame(input int base, input string name);
        int r, c;
        for (int i = 0; i < W * H; i++) begin
            if (base + i < outPix.size()) begin
                r = i / W;
                c = i % W;
                checkOutput($sformatf("%s_row[%0d]", name, i), outRow[base + i], r);
                checkOutput($sformatf("%s_col[%0d]", name, i), outCol[base + i], c);
                checkOutput($sformatf("%s_pix[%0d]", name, i), outPix[base + i], expectedOf(r, c));
            end
        end
    endtask

    task automatic checkSingleFrame(input string name);
        checkOutput({name, "_count"}, outPix.size(), W * H);
        checkOutput({name, "_doneCount"}, doneIdx.size(), 1);
        checkOutput({name, "_doneIndex"}, (doneIdx.size() > 0) ? doneIdx[0] : -1, W * H - 1);
        verifyFrame(0, name);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        setIdle();
        rst_n = 1'b0;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            gray_valid = 1'($urandom); gray = 8'($urandom);
            mean_valid = 1'($urandom); mean_out = 8'($urandom);
            center_row = 16'($urandom); center_col = 16'($urandom);
            checkOutput("resetOutputs", {pix_valid, pix_out, pix_row, pix_col, frame_done, overflow, sync_err}, 0);
        end
        @(negedge clk);
        setIdle();
        rst_n = 1'b1;
        clearCapture();
        repeat (100) @(negedge clk);
        checkOutput("idleNoPixels", outPix.size(), 0);

        $display("[TB] frame, gray every cycle");
        clearCapture();
        applyStimulus(0, 10, 1'b0, 100000);
        waitFrameDone(500);
        @(negedge clk);
        checkSingleFrame("f1");
        checkOutput("f1_overflow", overflow, 0);
        checkOutput("f1_syncErr", sync_err, 0);
        checkOutput("f1_meanLatency", (outCyc.size() > 27) ? outCyc[27] - meanDrive33 : -1, 3);

        $display("[TB] frame, gray gaps and late means");
        clearCapture();
        applyStimulus(10, 40, 1'b0, 100000);
        waitFrameDone(2000);
        @(negedge clk);
        checkSingleFrame("f2");
        checkOutput("f2_overflow", overflow, 0);
        checkOutput("f2_syncErr", sync_err, 0);
        checkOutput("f2_meanLatency", (outCyc.size() > 27) ? outCyc[27] - meanDrive33 : -1, 3);

        $display("[TB] frame with misaligned mean tag");
        clearCapture();
        applyStimulus(0, 10, 1'b1, 100000);
        waitFrameDone(500);
        @(negedge clk);
        checkSingleFrame("f3");
        checkOutput("f3_syncErr", sync_err, 1);
        checkOutput("f3_overflow", overflow, 0);

        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("flagsClearedByReset", {overflow, sync_err}, 0);

        $display("[TB] two-line buffer overflow");
        outCnt2 = 0; doneCnt2 = 0;
        for (int i = 0; i < W * H; i++) begin
            if (i == 43) checkOutput("ovfBeforeLimit", overflow2, 0);
            if (i == 45) checkOutput("ovfAtLimit", overflow2, 1);
            gray_valid2 = 1'b1;
            gray2 = 8'(grayOf(i / W, i % W));
            @(negedge clk);
        end
        gray_valid2 = 1'b0;
        repeat (10) @(negedge clk);
        checkOutput("ovfStallCount", outCnt2, 27);
        for (int k = 0; k < 4; k++) begin
            mean_valid2 = 1'b1;
            center_row2 = 16'(3 + k / 2);
            center_col2 = 16'(3 + k % 2);
            mean_out2 = 8'(meanOf(3 + k / 2, 3 + k % 2));
            @(negedge clk);
            mean_valid2 = 1'b0;
            if (k == 1) begin
                repeat (20) @(negedge clk);
                checkOutput("ovfRow3Count", outCnt2, 35);
            end
        end
        repeat (20) @(negedge clk);
        checkOutput("ovfDroppedCount", outCnt2, 43);
        checkOutput("ovfLastPixel", lastPix2, grayOf(5, 2));
        checkOutput("ovfNoFrameDone", doneCnt2, 0);

        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] two frames back to back");
        clearCapture();
        applyStimulus(0, 10, 1'b0, 100000);
        waitFrameDone(500);
        @(negedge clk);
        applyStimulus(0, 10, 1'b0, 100000);
        waitFrameDone(500);
        @(negedge clk);
        checkOutput("b2b_count", outPix.size(), 2 * W * H);
        checkOutput("b2b_doneCount", doneIdx.size(), 2);
        checkOutput("b2b_done2Index", (doneIdx.size() > 1) ? doneIdx[1] : -1, 2 * W * H - 1);
        checkOutput("b2b_overflow", overflow, 0);
        verifyFrame(0, "b2bA");
        verifyFrame(W * H, "b2bB");

        $display("[TB] reset during a frame");
        clearCapture();
        applyStimulus(0, 10, 1'b1, 63);
        repeat (3) @(negedge clk);
        checkOutput("midStallCount", outPix.size(), 27);
        checkOutput("midSyncErrSet", sync_err, 1);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("midResetOutputs", {pix_valid, pix_out, pix_row, pix_col, frame_done, overflow, sync_err}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        clearCapture();
        applyStimulus(0, 10, 1'b0, 100000);
        waitFrameDone(500);
        @(negedge clk);
        checkSingleFrame("fresh");
        checkOutput("fresh_flags", {overflow, sync_err}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
